// File: rtl/code_patch_loader_pkg.sv
// Shared types and constants for the code-patch loader: FSM state encoding,
// sticky error codes, the table magic and the register-index width helper.
package code_patch_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HDR_REQ   = 4'd1,
        ST_HDR_WAIT  = 4'd2,
        ST_CHECK     = 4'd3,
        ST_ENT_REQ   = 4'd4,
        ST_ENT_WAIT  = 4'd5,
        ST_WRITE     = 4'd6,
        ST_CSUM_REQ  = 4'd7,
        ST_CSUM_WAIT = 4'd8,
        ST_DONE      = 4'd9,
        ST_ERROR     = 4'd10
    } state_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_MAGIC   = 3'd1;
    localparam logic [2:0] ERR_COUNT   = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_CSUM    = 3'd4;

    localparam logic [15:0] PATCH_MAGIC = 16'hC0DE;

    // Index width for a register file of n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/code_patch_loader_if.sv
// Source-memory read port and patch-register write port of the loader.
// master = loader side, slave = memory / patch-core side.
interface code_patch_loader_if #(
    parameter int SRC_AW = 8,
    parameter int W      = 32,
    parameter int IDX_W  = 5
);
    logic              src_req_o;
    logic [SRC_AW-1:0] src_addr_o;
    logic              src_rvalid_i;
    logic [W-1:0]      src_rdata_i;
    logic              ctl_pat_we_o;
    logic [IDX_W-1:0]  ctl_pat_idx_o;
    logic [W-1:0]      ctl_pat_data_o;

    modport master (
        output src_req_o, src_addr_o, ctl_pat_we_o, ctl_pat_idx_o, ctl_pat_data_o,
        input  src_rvalid_i, src_rdata_i
    );

    modport slave (
        input  src_req_o, src_addr_o, ctl_pat_we_o, ctl_pat_idx_o, ctl_pat_data_o,
        output src_rvalid_i, src_rdata_i
    );
endinterface

// File: rtl/code_patch_loader_fetch_timer.sv
// Single-outstanding read helper: forwards the request pulse and runs a
// down-counter that flags a timeout when the wait window closes without data.
module code_patch_loader_fetch_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic issue,
    input  logic waiting,
    input  logic rvalid_raw,
    output logic req,
    output logic rvalid,
    output logic timeout
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Loaded on the request cycle; reaches zero on the TIMEOUT-th wait cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= CNT_LOAD;
        end else if (waiting && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign req     = issue;
    assign rvalid  = waiting & rvalid_raw;
    // Data arriving on the terminal cycle wins over the timeout.
    assign timeout = waiting & ~rvalid_raw & (cnt == '0);

endmodule

// File: rtl/code_patch_loader.sv
// Boot-time loader: reads a patch table from source memory and writes it into
// the patch registers. Define CODE_PATCH_LOADER_CSUM_EN to add the XOR checksum word.
//
// state     | meaning
// IDLE      | waiting for start_i
// HDR_REQ   | read request for header word
// HDR_WAIT  | waiting for header data
// CHECK     | validate magic and entry count
// ENT_REQ   | read request for entry ent_cnt
// ENT_WAIT  | waiting for entry data
// WRITE     | one-cycle register write strobe
// CSUM_REQ  | read request for checksum word
// CSUM_WAIT | waiting for checksum, compare against running XOR
// DONE      | load succeeded
// ERROR     | load failed, err_o holds the cause
module code_patch_loader
    import code_patch_loader_pkg::*;
#(
    parameter int ADDR_WIDTH          = 32,
    parameter int DATA_WIDTH          = 12,
    parameter int NUM_REGS            = 21,
    parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
    parameter int SRC_AW              = 8,
    parameter int TIMEOUT             = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [SRC_AW-1:0] src_base_i,
    code_patch_loader_if.master bus,
    output logic              cfg_pat_gen_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        err_o
);
    localparam int W     = SUB_REGS_DATA_WIDTH;
    localparam int IDX_W = idx_width(NUM_REGS);

    if (W < 24) begin : g_width_check
        $error("code_patch_loader: register word width must be at least 24 bits");
    end

`ifdef CODE_PATCH_LOADER_CSUM_EN
    localparam state_e ST_FINISH = ST_CSUM_REQ;
`else
    localparam state_e ST_FINISH = ST_DONE;
`endif

    state_e            state, next_state;
    logic [SRC_AW-1:0] base_q;
    logic [7:0]        hdr_n;
    logic              magic_ok;
    logic [7:0]        ent_cnt;
    logic [W-1:0]      xor_acc;
    logic [IDX_W-1:0]  pat_idx;
    logic [W-1:0]      pat_data;

    logic              issue, waiting, req, rd_valid, rd_timeout;
    logic              we, busy, accept_start;
    logic [SRC_AW-1:0] addr;
    logic [2:0]        err_code;
    logic              n_too_big, last_entry, csum_ok;

    code_patch_loader_fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .issue      (issue),
        .waiting    (waiting),
        .rvalid_raw (bus.src_rvalid_i),
        .req        (req),
        .rvalid     (rd_valid),
        .timeout    (rd_timeout)
    );

    assign accept_start = start_i &&
                          ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign n_too_big    = {1'b0, hdr_n} > 9'(NUM_REGS);
    assign last_entry   = (ent_cnt == (hdr_n - 8'd1));
    assign csum_ok      = (bus.src_rdata_i == xor_acc);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start_i) next_state = ST_HDR_REQ;
            ST_HDR_REQ:  next_state = ST_HDR_WAIT;
            ST_HDR_WAIT: begin
                if (rd_valid)        next_state = ST_CHECK;
                else if (rd_timeout) next_state = ST_ERROR;
            end
            ST_CHECK: begin
                if (!magic_ok || n_too_big) next_state = ST_ERROR;
                else if (hdr_n == 8'd0)     next_state = ST_FINISH;
                else                        next_state = ST_ENT_REQ;
            end
            ST_ENT_REQ:  next_state = ST_ENT_WAIT;
            ST_ENT_WAIT: begin
                if (rd_valid)        next_state = ST_WRITE;
                else if (rd_timeout) next_state = ST_ERROR;
            end
            ST_WRITE:    next_state = last_entry ? ST_FINISH : ST_ENT_REQ;
            ST_CSUM_REQ: next_state = ST_CSUM_WAIT;
            ST_CSUM_WAIT: begin
                if (rd_valid)        next_state = csum_ok ? ST_DONE : ST_ERROR;
                else if (rd_timeout) next_state = ST_ERROR;
            end
            default:     next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        issue    = 1'b0;
        waiting  = 1'b0;
        we       = 1'b0;
        busy     = 1'b1;
        addr     = '0;
        err_code = ERR_NONE;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: busy = 1'b0;
            ST_HDR_REQ: begin
                issue = 1'b1;
                addr  = base_q;
            end
            ST_HDR_WAIT, ST_ENT_WAIT: begin
                waiting = 1'b1;
                if (rd_timeout) err_code = ERR_TIMEOUT;
            end
            ST_CHECK: begin
                if (!magic_ok)      err_code = ERR_MAGIC;
                else if (n_too_big) err_code = ERR_COUNT;
            end
            ST_ENT_REQ: begin
                issue = 1'b1;
                addr  = base_q + SRC_AW'({1'b0, ent_cnt} + 9'd1);
            end
            ST_WRITE: we = 1'b1;
            ST_CSUM_REQ: begin
                issue = 1'b1;
                addr  = base_q + SRC_AW'({1'b0, hdr_n} + 9'd1);
            end
            ST_CSUM_WAIT: begin
                waiting = 1'b1;
                if (rd_timeout)             err_code = ERR_TIMEOUT;
                else if (rd_valid && !csum_ok) err_code = ERR_CSUM;
            end
            default: busy = 1'b0;
        endcase
    end

    // Sticky status: cleared by an accepted restart, set on entry to DONE/ERROR.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_o        <= 1'b0;
            cfg_pat_gen_o <= 1'b0;
            err_o         <= ERR_NONE;
        end else if (accept_start) begin
            done_o        <= 1'b0;
            cfg_pat_gen_o <= 1'b0;
            err_o         <= ERR_NONE;
        end else if ((next_state == ST_DONE) && (state != ST_DONE)) begin
            done_o        <= 1'b1;
            cfg_pat_gen_o <= (hdr_n != 8'd0);
        end else if ((next_state == ST_ERROR) && (state != ST_ERROR)) begin
            err_o         <= err_code;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q   <= '0;
            hdr_n    <= '0;
            magic_ok <= 1'b0;
            ent_cnt  <= '0;
            xor_acc  <= '0;
            pat_idx  <= '0;
            pat_data <= '0;
        end else begin
            if (accept_start) base_q <= src_base_i;
            if ((state == ST_HDR_WAIT) && rd_valid) begin
                hdr_n    <= bus.src_rdata_i[7:0];
                magic_ok <= (bus.src_rdata_i[W-1 -: 16] == PATCH_MAGIC);
                xor_acc  <= bus.src_rdata_i;
            end
            if (state == ST_CHECK) ent_cnt <= '0;
            // Index/data registers change only here, so they hold between writes.
            if ((state == ST_ENT_WAIT) && rd_valid) begin
                xor_acc  <= xor_acc ^ bus.src_rdata_i;
                pat_idx  <= IDX_W'(ent_cnt);
                pat_data <= bus.src_rdata_i;
            end
            if (state == ST_WRITE) ent_cnt <= ent_cnt + 8'd1;
        end
    end

    assign busy_o             = busy;
    assign bus.src_req_o      = req;
    assign bus.src_addr_o     = addr;
    assign bus.ctl_pat_we_o   = we;
    assign bus.ctl_pat_idx_o  = pat_idx;
    assign bus.ctl_pat_data_o = pat_data;

endmodule

// File: tb/tb_code_patch_loader.sv
// Directed bench for code_patch_loader: behavioural source memory with per-request
// latency control, write/request logging, and immediate-assertion checks.
module tb_code_patch_loader;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] src_base_i = 8'h00;
    logic       cfg_pat_gen_o, busy_o, done_o;
    logic [2:0] err_o;

    code_patch_loader_if #(.SRC_AW(8), .W(32), .IDX_W(5)) bus();

    code_patch_loader #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (12),
        .NUM_REGS   (21),
        .SRC_AW     (8),
        .TIMEOUT    (64)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .src_base_i    (src_base_i),
        .bus           (bus),
        .cfg_pat_gen_o (cfg_pat_gen_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_n = 0, drop_req = -1, slow_req = -1, slow_lat = 1;
    int          req_cyc [16];
    logic [7:0]  req_addr [16];
    int          wr_n = 0;
    logic [4:0]  wr_idx [32];
    logic [31:0] wr_data [32];
    int          wr_cyc [32];
    int          err_cyc = -1;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [7:0]  pend_addr = 8'h00;

    // Memory responder and bus monitor, active on the falling edge.
    initial begin
        bus.src_rvalid_i = 1'b0;
        bus.src_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            bus.src_rvalid_i = 1'b0;
            if (!rst_ni) begin
                pend = 1'b0;
            end else if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.src_rvalid_i = 1'b1;
                    bus.src_rdata_i  = mem[pend_addr];
                    pend = 1'b0;
                end
            end
            if (rst_ni && bus.src_req_o) begin
                if (req_n < 16) begin
                    req_cyc[req_n]  = cyc;
                    req_addr[req_n] = bus.src_addr_o;
                end
                if (req_n != drop_req) begin
                    pend      = 1'b1;
                    pend_cnt  = (req_n == slow_req) ? slow_lat : 1;
                    pend_addr = bus.src_addr_o;
                end
                req_n++;
            end
            if (bus.ctl_pat_we_o) begin
                if (wr_n < 32) begin
                    wr_idx[wr_n]  = bus.ctl_pat_idx_o;
                    wr_data[wr_n] = bus.ctl_pat_data_o;
                    wr_cyc[wr_n]  = cyc;
                end
                wr_n++;
            end
            if ((err_o != 3'd0) && (err_cyc < 0)) err_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
        #1;
    endtask

    task automatic start_load(input logic [7:0] base);
        wr_n    = 0;
        req_n   = 0;
        err_cyc = -1;
        tick(1);
        src_base_i = base;
        start_i    = 1'b1;
        tick(1);
        start_i    = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy_o === 1'b1) && (n < budget)) begin
            tick(1);
            n++;
        end
        chk({tag, "_finished"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hC0DE_0003;
        mem[8'h11] = 32'hAAAA_0001;
        mem[8'h12] = 32'hBBBB_0002;
        mem[8'h13] = 32'hCCCC_0003;
        mem[8'h14] = mem[8'h10] ^ mem[8'h11] ^ mem[8'h12] ^ mem[8'h13];
        mem[8'h20] = 32'hBEEF_0003;
        mem[8'h28] = 32'hC0DE_0016;
        mem[8'h30] = 32'hC0DE_0000;
        mem[8'h31] = 32'hC0DE_0000;
        mem[8'h40] = 32'hC0DE_0015;
        mem[8'h56] = mem[8'h40];
        for (int i = 0; i < 21; i++) begin
            mem[8'h41 + i] = 32'h1000_0000 + i;
            mem[8'h56]     = mem[8'h56] ^ (32'h1000_0000 + i);
        end
        mem[8'hFE] = 32'hC0DE_0002;
        mem[8'hFF] = 32'h1234_5678;
        mem[8'h00] = 32'h9ABC_DEF0;
        mem[8'h01] = mem[8'hFE] ^ mem[8'hFF] ^ mem[8'h00];
        mem[8'h60] = 32'hC0DE_0003;
        mem[8'h61] = 32'h5000_0001;
        mem[8'h62] = 32'h5000_0002;
        mem[8'h63] = 32'h5000_0003;
        mem[8'h64] = mem[8'h60] ^ mem[8'h61] ^ mem[8'h62] ^ mem[8'h63];

        // Reset state
        tick(3);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_gen", 32'(cfg_pat_gen_o), 32'd0);
        chk("rst_we", 32'(bus.ctl_pat_we_o), 32'd0);
        chk("rst_req", 32'(bus.src_req_o), 32'd0);
        rst_ni = 1'b1;
        tick(2);

        // Basic three-entry load, with a start pulse during the load that must be ignored
        start_load(8'h10);
        chk("basic_busy", 32'(busy_o), 32'd1);
        tick(4);
        src_base_i = 8'h20;
        start_i    = 1'b1;
        tick(1);
        start_i    = 1'b0;
        wait_idle("basic", 300);
        chk("basic_done", 32'(done_o), 32'd1);
        chk("basic_gen", 32'(cfg_pat_gen_o), 32'd1);
        chk("basic_err", 32'(err_o), 32'd0);
        chk("basic_nwr", 32'(wr_n), 32'd3);
        chk("basic_hdr_addr", 32'(req_addr[0]), 32'h10);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("basic_idx%0d", i), 32'(wr_idx[i]), 32'(i));
            chk($sformatf("basic_data%0d", i), wr_data[i], mem[8'h11 + i]);
        end
        chk("basic_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd3);
        chk("basic_hold_idx", 32'(bus.ctl_pat_idx_o), 32'd2);

        // Bad magic
        start_load(8'h20);
        chk("magic_clear_done", 32'(done_o), 32'd0);
        wait_idle("magic", 300);
        chk("magic_err", 32'(err_o), 32'd1);
        chk("magic_nwr", 32'(wr_n), 32'd0);
        chk("magic_gen", 32'(cfg_pat_gen_o), 32'd0);
        chk("magic_done", 32'(done_o), 32'd0);

        // Entry count one above the register file size
        start_load(8'h28);
        wait_idle("count", 300);
        chk("count_err", 32'(err_o), 32'd2);
        chk("count_nwr", 32'(wr_n), 32'd0);

        // Full register file
        start_load(8'h40);
        wait_idle("full", 300);
        chk("full_err", 32'(err_o), 32'd0);
        chk("full_done", 32'(done_o), 32'd1);
        chk("full_nwr", 32'(wr_n), 32'd21);
        chk("full_last_idx", 32'(wr_idx[20]), 32'd20);
        chk("full_last_data", wr_data[20], 32'h1000_0014);

        // Empty table: success without enabling patching
        start_load(8'h30);
        wait_idle("empty", 300);
        chk("empty_done", 32'(done_o), 32'd1);
        chk("empty_gen", 32'(cfg_pat_gen_o), 32'd0);
        chk("empty_nwr", 32'(wr_n), 32'd0);

        // Address wraparound
        start_load(8'hFE);
        wait_idle("wrap", 300);
        chk("wrap_addr0", 32'(req_addr[0]), 32'hFE);
        chk("wrap_addr1", 32'(req_addr[1]), 32'hFF);
        chk("wrap_addr2", 32'(req_addr[2]), 32'h00);
`ifdef CODE_PATCH_LOADER_CSUM_EN
        chk("wrap_addr3", 32'(req_addr[3]), 32'h01);
        chk("wrap_nreq", 32'(req_n), 32'd4);
`else
        chk("wrap_nreq", 32'(req_n), 32'd3);
`endif
        chk("wrap_data1", wr_data[1], 32'h9ABC_DEF0);
        chk("wrap_done", 32'(done_o), 32'd1);

        // Entry 1 never answered
        drop_req = 2;
        start_load(8'h60);
        wait_idle("tmo", 300);
        drop_req = -1;
        chk("tmo_err", 32'(err_o), 32'd3);
        chk("tmo_nwr", 32'(wr_n), 32'd1);
        chk("tmo_gen", 32'(cfg_pat_gen_o), 32'd0);
        chk("tmo_latency", 32'(err_cyc - req_cyc[2]), 32'd65);

        // Entry 1 answered on the last cycle of the window; restart clears the error
        slow_req = 2;
        slow_lat = 64;
        start_load(8'h60);
        chk("late_err_cleared", 32'(err_o), 32'd0);
        wait_idle("late", 300);
        slow_req = -1;
        chk("late_err", 32'(err_o), 32'd0);
        chk("late_done", 32'(done_o), 32'd1);
        chk("late_nwr", 32'(wr_n), 32'd3);
        chk("late_data2", wr_data[2], 32'h5000_0003);

`ifdef CODE_PATCH_LOADER_CSUM_EN
        // Corrupted checksum, then a clean reload
        mem[8'h14] = mem[8'h14] ^ 32'h0000_0100;
        start_load(8'h10);
        wait_idle("csum_bad", 300);
        chk("csum_bad_err", 32'(err_o), 32'd4);
        chk("csum_bad_gen", 32'(cfg_pat_gen_o), 32'd0);
        chk("csum_bad_done", 32'(done_o), 32'd0);
        chk("csum_bad_nwr", 32'(wr_n), 32'd3);
        mem[8'h14] = mem[8'h14] ^ 32'h0000_0100;
        start_load(8'h10);
        chk("csum_restart_err", 32'(err_o), 32'd0);
        wait_idle("csum_ok", 300);
        chk("csum_ok_done", 32'(done_o), 32'd1);
        chk("csum_ok_gen", 32'(cfg_pat_gen_o), 32'd1);
`endif

        // Reset in the middle of a long load
        start_load(8'h40);
        tick(10);
        rst_ni = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_we", 32'(bus.ctl_pat_we_o), 32'd0);
        chk("midrst_req", 32'(bus.src_req_o), 32'd0);
        chk("midrst_err", 32'(err_o), 32'd0);
        chk("midrst_gen", 32'(cfg_pat_gen_o), 32'd0);
        tick(2);
        rst_ni = 1'b1;
        w0 = wr_n;
        tick(30);
        chk("midrst_nowrites", 32'(wr_n), 32'(w0));
        chk("midrst_idle", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
